atm_pin_verifier: RTL

- Card-side responder of the PIN-entry interface: accepts PIN digits one at a time from the keypad front end and compares the full PIN against the code read from the inserted card.
- Grants access when the PIN matches.
- Counts failed attempts and runs an inactivity timer; ejects the card on attempt exhaustion or timeout.
- Sits between the keypad/card-reader inputs and the balance/withdrawal datapath, which is enabled by access_ok.

---
 rtl/atm_pkg.sv | 27 ++
 rtl/atm_idle_timer.sv | 34 +++
 rtl/atm_pin_verifier.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared types and default parameters for the ATM PIN verifier slice.
// Holds the controller state encoding, the eject-cause encoding and the
// default sizing used by atm_pin_verifier and its timer.
package atm_pkg;

    localparam int PIN_DIGITS_DEF = 4;    // digits per PIN
    localparam int DIGIT_W_DEF    = 4;    // bits per digit
    localparam int MAX_TRIES_DEF  = 3;    // failed attempts before ejection (1..3)
    localparam int TIMEOUT_DEF    = 500;  // idle cycles allowed in ENTRY
    localparam int TIME_W_DEF     = 9;    // countdown timer width

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ENTRY,
        CHECK,
        GRANTED,
        EJECT
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        TENTATIVA,
        TEMPO
    } cause_t;

endpackage

// File: rtl/atm_idle_timer.sv
// Loadable down-counter used as an inactivity timer.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset (count clears to 0)
//   load     - load load_val this cycle (wins over en)
//   en       - decrement by one this cycle; holds at zero
//   load_val - reload value
//   count    - current remaining cycles
//   zero     - count == 0
module atm_idle_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/atm_pin_verifier.sv
// Card-side PIN verifier: collects keypad digits, compares the full PIN with
// the code latched from the card, counts failed attempts and ejects the card
// on attempt exhaustion or inactivity timeout.
// Ports:
//   clk, rst_n       - clock and synchronous active-low reset
//   card_in          - card present (level)
//   card_code        - stored PIN from card, digit 0 in the LSBs
//   digit            - keypad digit, qualified by digit_valid strobe
//   cancel           - user abort strobe
//   access_ok        - PIN accepted, session open (level)
//   pin_fail         - one-cycle pulse per wrong PIN
//   tries_left       - remaining attempts
//   tempo            - remaining idle cycles
//   ejeta_tentativa  - one-cycle eject pulse, attempts exhausted
//   ejeta_tempo      - one-cycle eject pulse, timeout
//   busy             - high in every state except IDLE
module atm_pin_verifier
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS = PIN_DIGITS_DEF,
    parameter int DIGIT_W    = DIGIT_W_DEF,
    parameter int MAX_TRIES  = MAX_TRIES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int TIME_W     = TIME_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          card_in,
    input  logic [PIN_DIGITS*DIGIT_W-1:0] card_code,
    input  logic [DIGIT_W-1:0]            digit,
    input  logic                          digit_valid,
    input  logic                          cancel,
    output logic                          access_ok,
    output logic                          pin_fail,
    output logic [1:0]                    tries_left,
    output logic [TIME_W-1:0]             tempo,
    output logic                          ejeta_tentativa,
    output logic                          ejeta_tempo,
    output logic                          busy
);

    localparam int                CODE_W     = PIN_DIGITS * DIGIT_W;
    localparam int                IDX_W      = (PIN_DIGITS > 1) ? $clog2(PIN_DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(PIN_DIGITS - 1);
    localparam logic [1:0]        TRIES_INIT = 2'(MAX_TRIES);
    localparam logic [TIME_W-1:0] TIME_INIT  = TIME_W'(TIMEOUT);

    state_t             state, state_nx;
    cause_t             cause, cause_nx;
    logic [CODE_W-1:0]  code_r;
    logic [CODE_W-1:0]  entry_r;
    logic [IDX_W-1:0]   idx;
    logic               armed;      // cleared by ejection, set once card_in seen low

    logic               abort;
    logic               digit_take;
    logic               pin_match;
    logic               check_fail;
    logic               tmr_load;
    logic               tmr_en;
    logic               tmr_zero;

    // Card removal outranks cancel; both return to IDLE from any busy state.
    // EJECT always finishes its pulse, so cancel is not an abort there.
    always_comb begin
        abort      = (state != IDLE) && (!card_in || (cancel && (state != EJECT)));
        digit_take = (state == ENTRY) && !abort && digit_valid;
        pin_match  = (entry_r == code_r);
        check_fail = (state == CHECK) && !abort && !pin_match;
        tmr_load   = (state == LOAD) || digit_take || (check_fail && (tries_left > 2'd1));
        tmr_en     = (state == ENTRY) && !abort && !digit_valid;
    end

    atm_idle_timer #(
        .W (TIME_W)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (TIME_INIT),
        .count    (tempo),
        .zero     (tmr_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cause <= NONE;
        end else begin
            state <= state_nx;
            cause <= cause_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        cause_nx = cause;
        if (abort) begin
            state_nx = IDLE;
            cause_nx = NONE;
        end else begin
            case (state)
                IDLE:    if (card_in && armed) state_nx = LOAD;
                LOAD:    state_nx = ENTRY;
                ENTRY: begin
                    if (digit_valid) begin
                        if (idx == LAST_IDX) state_nx = CHECK;
                    end else if (tmr_zero) begin
                        state_nx = EJECT;
                        cause_nx = TEMPO;
                    end
                end
                CHECK: begin
                    if (pin_match) begin
                        state_nx = GRANTED;
                    end else if (tries_left <= 2'd1) begin
                        state_nx = EJECT;
                        cause_nx = TENTATIVA;
                    end else begin
                        state_nx = ENTRY;
                    end
                end
                GRANTED: state_nx = GRANTED;
                EJECT: begin
                    state_nx = IDLE;
                    cause_nx = NONE;
                end
                default: begin
                    state_nx = IDLE;
                    cause_nx = NONE;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy            = (state != IDLE);
        access_ok       = (state == GRANTED);
        ejeta_tentativa = (state == EJECT) && (cause == TENTATIVA);
        ejeta_tempo     = (state == EJECT) && (cause == TEMPO);
    end

    // Digit register, attempt counter and rearm flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_r     <= '0;
            entry_r    <= '0;
            idx        <= '0;
            tries_left <= TRIES_INIT;
            pin_fail   <= 1'b0;
            armed      <= 1'b1;
        end else begin
            pin_fail <= check_fail;

            if (state == LOAD) begin
                code_r     <= card_code;
                entry_r    <= '0;
                idx        <= '0;
                tries_left <= TRIES_INIT;
            end else if (digit_take) begin
                entry_r[int'(idx)*DIGIT_W +: DIGIT_W] <= digit;
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end else if (check_fail) begin
                entry_r <= '0;
                idx     <= '0;
                if (tries_left != 2'd0) tries_left <= tries_left - 2'd1;
            end

            if (state == EJECT) begin
                armed <= 1'b0;
            end else if (!card_in) begin
                armed <= 1'b1;
            end
        end
    end

endmodule
